// File: rtl/sign_scrambler.sv
// sign_scrambler: serialises one macroblock's natural-order sign word in scan order.
// A block word and its sign count come from the block FIFO. Scan positions come from
// the position FIFO. The module emits one sign bit per position and flags the final bit.
// Exactly blk_size positions are read for each block, so reads never run into the next
// block. Position reads are throttled so that a 2-entry skid buffer can never overflow.

module sign_scrambler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [63:0] blk_in,
  input  logic [6:0]  blk_size,
  input  logic        blk_empty,
  output logic        blk_rd,
  input  logic [6:0]  pos_in,
  input  logic        pos_empty,
  output logic        pos_rd,
  input  logic        sign_full,
  output logic        sign_out,
  output logic        sign_wr,
  output logic        sign_last,
  output logic        size_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [63:0] sign_word;
  logic [6:0]  size;
  logic [6:0]  rd_cnt;
  logic [6:0]  em_cnt;
  logic        pos_valid;
  logic [6:0]  skid0;
  logic [6:0]  skid1;
  logic [1:0]  skid_occ;
  logic        flag_err;

  logic        size_ok;
  logic        have_head;
  logic [6:0]  head;
  logic        emit;
  logic        is_last;
  logic        flag_bad;
  logic        pop;
  logic        push;
  logic [1:0]  occ_next;
  logic [6:0]  skid0_next;
  logic [6:0]  skid1_next;
  logic [2:0]  pending;

  assign size_ok   = (blk_size != 7'd0) && (blk_size <= 7'd64);
  assign pending   = {1'b0, skid_occ} + {2'b00, pos_valid};

  // The head is the oldest buffered position, or the position arriving this cycle
  // when the buffer is empty, which allows the first bit to be emitted without an extra cycle.
  assign have_head = (skid_occ != 2'd0) || pos_valid;
  assign head      = (skid_occ != 2'd0) ? skid0 : pos_in;
  assign emit      = (state == RUN) && have_head && !sign_full;
  assign is_last   = (em_cnt == size - 7'd1);
  assign flag_bad  = (head[6] != is_last);

  assign blk_rd = clk_en && !rst && (state == IDLE) && !blk_empty;
  assign pos_rd = clk_en && !rst && (state == RUN) && !pos_empty &&
                  (rd_cnt < size) && (pending < 3'd2);

  assign pop  = emit && (skid_occ != 2'd0);
  assign push = pos_valid && !(emit && (skid_occ == 2'd0));

  // Next skid-buffer contents: pop the head if it was emitted, then append any arrival
  // that was not consumed directly in the same cycle.
  always_comb begin
    skid0_next = skid0;
    skid1_next = skid1;
    occ_next   = skid_occ;
    if (pop) begin
      skid0_next = skid1;
      occ_next   = skid_occ - 2'd1;
    end
    if (push) begin
      if (occ_next == 2'd0) begin
        skid0_next = pos_in;
      end else begin
        skid1_next = pos_in;
      end
      occ_next = occ_next + 2'd1;
    end
  end

  // The data registers have no reset. They hold the captured word and the buffered positions.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (state == LOAD) begin
        sign_word <= blk_in;
      end
      skid0 <= skid0_next;
      skid1 <= skid1_next;
    end
  end

  // Control FSM, counters and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      size      <= 7'd0;
      rd_cnt    <= 7'd0;
      em_cnt    <= 7'd0;
      pos_valid <= 1'b0;
      skid_occ  <= 2'd0;
      flag_err  <= 1'b0;
      sign_out  <= 1'b0;
      sign_wr   <= 1'b0;
      sign_last <= 1'b0;
      size_err  <= 1'b0;
    end else if (!clk_en) begin
      sign_wr  <= 1'b0;
      size_err <= 1'b0;
    end else begin
      sign_wr   <= 1'b0;
      size_err  <= 1'b0;
      pos_valid <= pos_rd;
      skid_occ  <= occ_next;
      case (state)
        IDLE: begin
          if (blk_rd) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          size     <= blk_size;
          rd_cnt   <= 7'd0;
          em_cnt   <= 7'd0;
          flag_err <= 1'b0;
          if (!size_ok) begin
            size_err <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (pos_rd) begin
            rd_cnt <= rd_cnt + 7'd1;
          end
          if (emit) begin
            sign_out  <= sign_word[6'd63 - head[5:0]];
            sign_wr   <= 1'b1;
            sign_last <= is_last;
            em_cnt    <= em_cnt + 7'd1;
            if (is_last) begin
              size_err <= flag_err || flag_bad;
              state    <= DONE;
            end else begin
              flag_err <= flag_err || flag_bad;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_scrambler.sv
// tb_sign_scrambler: the bench models both FIFOs with queues. It builds the expected
// serial stream from the block word and the scan positions, then compares that stream
// with what the scrambler emits, including the timing and stall behaviour.

module tb_sign_scrambler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        sign_full;
  logic [63:0] blk_in;
  logic [6:0]  blk_size;
  logic        blk_empty;
  logic        blk_rd;
  logic [6:0]  pos_in;
  logic        pos_empty;
  logic        pos_rd;
  logic        sign_out;
  logic        sign_wr;
  logic        sign_last;
  logic        size_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] bq_w[$];
  logic [6:0]  bq_s[$];
  logic [6:0]  pq[$];
  logic [6:0]  pl[$];
  logic        exp_bit[$];
  logic        exp_last[$];
  logic        exp_err[$];
  int          exp_lone;
  logic        mon_bit[$];
  logic        mon_last[$];
  logic        mon_err[$];
  int          mon_cyc[$];
  int          blkrd_cyc[$];
  int          posrd_cyc[$];
  int          lone_err;
  int          pos_reads;
  int          full_viol;
  logic        full_prev = 1'b0;
  logic        pos_hold  = 1'b0;

  sign_scrambler dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .blk_in    (blk_in),
    .blk_size  (blk_size),
    .blk_empty (blk_empty),
    .blk_rd    (blk_rd),
    .pos_in    (pos_in),
    .pos_empty (pos_empty),
    .pos_rd    (pos_rd),
    .sign_full (sign_full),
    .sign_out  (sign_out),
    .sign_wr   (sign_wr),
    .sign_last (sign_last),
    .size_err  (size_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // FIFO model: a read strobe seen mid-cycle presents the next entry after the clock edge.
  initial begin
    logic b;
    logic p;
    blk_in    = 64'd0;
    blk_size  = 7'd0;
    blk_empty = 1'b1;
    pos_in    = 7'd0;
    pos_empty = 1'b1;
    forever begin
      @(negedge clk);
      b = blk_rd;
      p = pos_rd;
      @(posedge clk);
      #1;
      if (b && bq_w.size() > 0) begin
        blk_in   = bq_w.pop_front();
        blk_size = bq_s.pop_front();
      end
      if (p && pq.size() > 0) begin
        pos_in = pq.pop_front();
      end
      blk_empty = (bq_w.size() == 0);
      pos_empty = (pq.size() == 0) || pos_hold;
    end
  end

  // Output monitor, sampled at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sign_wr) begin
        mon_bit.push_back(sign_out);
        mon_last.push_back(sign_last);
        mon_err.push_back(size_err);
        mon_cyc.push_back(cyc);
        if (full_prev) full_viol++;
      end else if (size_err) begin
        lone_err++;
      end
      if (blk_rd) blkrd_cyc.push_back(cyc);
      if (pos_rd) begin
        pos_reads++;
        posrd_cyc.push_back(cyc);
      end
      full_prev = sign_full;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout req=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    mon_bit.delete();
    mon_last.delete();
    mon_err.delete();
    mon_cyc.delete();
    blkrd_cyc.delete();
    posrd_cyc.delete();
    exp_bit.delete();
    exp_last.delete();
    exp_err.delete();
    exp_lone  = 0;
    lone_err  = 0;
    pos_reads = 0;
    full_viol = 0;
  endtask

  task automatic gen_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) begin
      pl.push_back({(i == n - 1), 6'($urandom_range(0, 63))});
    end
  endtask

  // Queues one block in the FIFOs and appends its expected serial stream.
  // Bit k is the sign at the k-th scan position, so it is word bit (63 - pos).
  task automatic add_block(input logic [63:0] w, input int sz);
    logic err;
    bq_w.push_back(w);
    bq_s.push_back(7'(sz));
    if (sz < 1 || sz > 64) begin
      exp_lone++;
      return;
    end
    err = 1'b0;
    for (int i = 0; i < sz; i++) begin
      if (pl[i][6] != (i == sz - 1)) err = 1'b1;
    end
    for (int i = 0; i < sz; i++) begin
      pq.push_back(pl[i]);
      exp_bit.push_back(w[63 - int'(pl[i][5:0])]);
      exp_last.push_back(i == sz - 1);
      exp_err.push_back((i == sz - 1) && err);
    end
  endtask

  task automatic wait_bits(input int n, input int limit, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (mon_bit.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    logic ok;
    int lat;
    rst = 1'b1;
    clk_en = 1'b1;
    sign_full = 1'b0;
    repeat (3) step();
    clear_obs();
    gen_pl(1);
    add_block({$urandom, $urandom}, 1);
    repeat (3) step();
    total++;
    if ({blk_rd, pos_rd, sign_wr, sign_last, sign_out, size_err} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b req=000000",
               {blk_rd, pos_rd, sign_wr, sign_last, sign_out, size_err});
    end
    rst = 1'b0;
    wait_bits(1, 40, ok);
    repeat (6) step();
    total++;
    if (ok !== 1'b1) begin bad++; $display("[TB] FAIL reset_timeout got=0 req=1"); end
    total++;
    if (mon_bit.size() !== 1) begin
      bad++; $display("[TB] FAIL size1_count got=%0d req=1", mon_bit.size());
    end
    for (int i = 0; i < exp_bit.size() && i < mon_bit.size(); i++) begin
      total++;
      if ({mon_bit[i], mon_last[i], mon_err[i]} !== {exp_bit[i], exp_last[i], exp_err[i]}) begin
        bad++;
        $display("[TB] FAIL size1_bit[%0d] got=%b%b%b req=%b%b%b", i, mon_bit[i], mon_last[i],
                 mon_err[i], exp_bit[i], exp_last[i], exp_err[i]);
      end
    end
    lat = (mon_cyc.size() > 0 && blkrd_cyc.size() > 0) ? mon_cyc[0] - blkrd_cyc[0] : -1;
    total++;
    if (lat !== 4) begin bad++; $display("[TB] FAIL size1_latency got=%0d req=4", lat); end
  endtask

  task automatic test_basic();
    logic ok;
    int lat0;
    int lat1;
    clear_obs();
    pl.delete();
    pl.push_back(7'd0);
    pl.push_back(7'd127);
    add_block(64'h8000_0000_0000_0001, 2);
    wait_bits(2, 50, ok);
    repeat (6) step();
    total++;
    if (ok !== 1'b1) begin bad++; $display("[TB] FAIL t1_timeout got=0 req=1"); end
    total++;
    if (mon_bit.size() !== 2) begin
      bad++; $display("[TB] FAIL t1_count got=%0d req=2", mon_bit.size());
    end
    for (int i = 0; i < exp_bit.size() && i < mon_bit.size(); i++) begin
      total++;
      if ({mon_bit[i], mon_last[i], mon_err[i]} !== {exp_bit[i], exp_last[i], exp_err[i]}) begin
        bad++;
        $display("[TB] FAIL t1_bit[%0d] got=%b%b%b req=%b%b%b", i, mon_bit[i], mon_last[i],
                 mon_err[i], exp_bit[i], exp_last[i], exp_err[i]);
      end
    end
    lat0 = (mon_cyc.size() > 0 && blkrd_cyc.size() > 0) ? mon_cyc[0] - blkrd_cyc[0] : -1;
    lat1 = (mon_cyc.size() > 1 && blkrd_cyc.size() > 0) ? mon_cyc[1] - blkrd_cyc[0] : -1;
    total++;
    if (lat0 !== 4) begin bad++; $display("[TB] FAIL t1_first_latency got=%0d req=4", lat0); end
    total++;
    if (lat1 !== 5) begin bad++; $display("[TB] FAIL t1_last_latency got=%0d req=5", lat1); end
    total++;
    if (lone_err !== 0) begin bad++; $display("[TB] FAIL t1_lone_err got=%0d req=0", lone_err); end
  endtask

  task automatic test_full_block();
    logic ok;
    int lat0;
    int latn;
    clear_obs();
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back({(i == 63), 6'(i)});
    add_block(64'hA5A5_A5A5_A5A5_A5A5, 64);
    wait_bits(64, 200, ok);
    repeat (6) step();
    total++;
    if (ok !== 1'b1) begin bad++; $display("[TB] FAIL t2_timeout got=0 req=1"); end
    total++;
    if (mon_bit.size() !== 64) begin
      bad++; $display("[TB] FAIL t2_count got=%0d req=64", mon_bit.size());
    end
    for (int i = 0; i < exp_bit.size() && i < mon_bit.size(); i++) begin
      total++;
      if ({mon_bit[i], mon_last[i], mon_err[i]} !== {exp_bit[i], exp_last[i], exp_err[i]}) begin
        bad++;
        $display("[TB] FAIL t2_bit[%0d] got=%b%b%b req=%b%b%b", i, mon_bit[i], mon_last[i],
                 mon_err[i], exp_bit[i], exp_last[i], exp_err[i]);
      end
    end
    lat0 = (mon_cyc.size() > 0 && blkrd_cyc.size() > 0) ? mon_cyc[0] - blkrd_cyc[0] : -1;
    latn = (mon_cyc.size() > 63 && blkrd_cyc.size() > 0) ? mon_cyc[63] - blkrd_cyc[0] : -1;
    total++;
    if (lat0 !== 4) begin bad++; $display("[TB] FAIL t2_first_latency got=%0d req=4", lat0); end
    total++;
    if (latn !== 67) begin bad++; $display("[TB] FAIL t2_last_latency got=%0d req=67", latn); end
    total++;
    if (pos_reads !== 64) begin bad++; $display("[TB] FAIL t2_pos_reads got=%0d req=64", pos_reads); end
  endtask

  task automatic test_stall_full();
    int full_cnt;
    clear_obs();
    gen_pl(3);
    add_block({$urandom, $urandom}, 3);
    full_cnt = 0;
    for (int k = 0; k < 300 && mon_bit.size() < 3; k++) begin
      step();
      pos_hold = 1'($urandom_range(0, 1));
      if (mon_bit.size() >= 1 && full_cnt < 5) begin
        sign_full = 1'b1;
        full_cnt++;
      end else begin
        sign_full = 1'b0;
      end
    end
    sign_full = 1'b0;
    pos_hold  = 1'b0;
    repeat (10) step();
    total++;
    if (mon_bit.size() !== 3) begin
      bad++; $display("[TB] FAIL t3_count got=%0d req=3", mon_bit.size());
    end
    for (int i = 0; i < exp_bit.size() && i < mon_bit.size(); i++) begin
      total++;
      if ({mon_bit[i], mon_last[i], mon_err[i]} !== {exp_bit[i], exp_last[i], exp_err[i]}) begin
        bad++;
        $display("[TB] FAIL t3_bit[%0d] got=%b%b%b req=%b%b%b", i, mon_bit[i], mon_last[i],
                 mon_err[i], exp_bit[i], exp_last[i], exp_err[i]);
      end
    end
    total++;
    if (full_viol !== 0) begin bad++; $display("[TB] FAIL t3_bit_while_full got=%0d req=0", full_viol); end
    total++;
    if (pos_reads !== 3) begin bad++; $display("[TB] FAIL t3_pos_reads got=%0d req=3", pos_reads); end
  endtask

  task automatic test_end_flag();
    logic ok;
    clear_obs();
    pl.delete();
    pl.push_back({1'b1, 6'($urandom_range(0, 63))});
    pl.push_back({1'b0, 6'($urandom_range(0, 63))});
    add_block({$urandom, $urandom}, 2);
    gen_pl(4);
    add_block({$urandom, $urandom}, 4);
    wait_bits(6, 80, ok);
    repeat (6) step();
    total++;
    if (ok !== 1'b1) begin bad++; $display("[TB] FAIL t4_timeout got=0 req=1"); end
    total++;
    if (mon_bit.size() !== 6) begin
      bad++; $display("[TB] FAIL t4_count got=%0d req=6", mon_bit.size());
    end
    for (int i = 0; i < exp_bit.size() && i < mon_bit.size(); i++) begin
      total++;
      if ({mon_bit[i], mon_last[i], mon_err[i]} !== {exp_bit[i], exp_last[i], exp_err[i]}) begin
        bad++;
        $display("[TB] FAIL t4_bit[%0d] got=%b%b%b req=%b%b%b", i, mon_bit[i], mon_last[i],
                 mon_err[i], exp_bit[i], exp_last[i], exp_err[i]);
      end
    end
    total++;
    if (lone_err !== 0) begin bad++; $display("[TB] FAIL t4_lone_err got=%0d req=0", lone_err); end
  endtask

  task automatic test_bad_size();
    logic ok;
    int first_pos;
    int third_blk;
    clear_obs();
    add_block({$urandom, $urandom}, 0);
    add_block({$urandom, $urandom}, 70);
    gen_pl(3);
    add_block({$urandom, $urandom}, 3);
    wait_bits(3, 80, ok);
    repeat (6) step();
    total++;
    if (ok !== 1'b1) begin bad++; $display("[TB] FAIL t5_timeout got=0 req=1"); end
    total++;
    if (lone_err !== exp_lone) begin
      bad++; $display("[TB] FAIL t5_size_err_pulses got=%0d req=%0d", lone_err, exp_lone);
    end
    total++;
    if (pos_reads !== 3) begin bad++; $display("[TB] FAIL t5_pos_reads got=%0d req=3", pos_reads); end
    total++;
    if (blkrd_cyc.size() !== 3) begin
      bad++; $display("[TB] FAIL t5_blk_reads got=%0d req=3", blkrd_cyc.size());
    end
    first_pos = (posrd_cyc.size() > 0) ? posrd_cyc[0] : -1;
    third_blk = (blkrd_cyc.size() > 2) ? blkrd_cyc[2] : 1000000;
    total++;
    if (!(first_pos > third_blk)) begin
      bad++; $display("[TB] FAIL t5_pos_rd_early got=%0d req=after %0d", first_pos, third_blk);
    end
    for (int i = 0; i < exp_bit.size() && i < mon_bit.size(); i++) begin
      total++;
      if ({mon_bit[i], mon_last[i], mon_err[i]} !== {exp_bit[i], exp_last[i], exp_err[i]}) begin
        bad++;
        $display("[TB] FAIL t5_bit[%0d] got=%b%b%b req=%b%b%b", i, mon_bit[i], mon_last[i],
                 mon_err[i], exp_bit[i], exp_last[i], exp_err[i]);
      end
    end
  endtask

  task automatic test_stall_and_reset();
    logic ok;
    int t0;
    int reads0;
    int stall_wr;
    // Hold clk_en low for three cycles while the block is in RUN.
    clear_obs();
    gen_pl(8);
    add_block({$urandom, $urandom}, 8);
    wait_bits(3, 60, ok);
    clk_en = 1'b0;
    t0 = cyc;
    reads0 = pos_reads;
    repeat (3) step();
    clk_en = 1'b1;
    total++;
    if (pos_reads !== reads0) begin
      bad++; $display("[TB] FAIL t6_reads_in_stall got=%0d req=%0d", pos_reads, reads0);
    end
    step();
    stall_wr = 0;
    foreach (mon_cyc[i]) if (mon_cyc[i] >= t0 + 1 && mon_cyc[i] <= t0 + 3) stall_wr++;
    total++;
    if (stall_wr !== 0) begin bad++; $display("[TB] FAIL t6_wr_in_stall got=%0d req=0", stall_wr); end
    wait_bits(8, 80, ok);
    repeat (6) step();
    total++;
    if (mon_bit.size() !== 8) begin
      bad++; $display("[TB] FAIL t6_count got=%0d req=8", mon_bit.size());
    end
    for (int i = 0; i < exp_bit.size() && i < mon_bit.size(); i++) begin
      total++;
      if ({mon_bit[i], mon_last[i], mon_err[i]} !== {exp_bit[i], exp_last[i], exp_err[i]}) begin
        bad++;
        $display("[TB] FAIL t6_bit[%0d] got=%b%b%b req=%b%b%b", i, mon_bit[i], mon_last[i],
                 mon_err[i], exp_bit[i], exp_last[i], exp_err[i]);
      end
    end
    // Assert reset in the middle of a block. The remaining positions are abandoned.
    clear_obs();
    gen_pl(10);
    add_block({$urandom, $urandom}, 10);
    wait_bits(2, 60, ok);
    rst = 1'b1;
    #1;
    total++;
    if ({blk_rd, pos_rd, sign_wr, sign_last, sign_out, size_err} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL t6_reset_outputs got=%b req=000000",
               {blk_rd, pos_rd, sign_wr, sign_last, sign_out, size_err});
    end
    pq.delete();
    clear_obs();
    gen_pl(3);
    add_block({$urandom, $urandom}, 3);
    step();
    step();
    total++;
    if (blk_rd !== 1'b0) begin bad++; $display("[TB] FAIL t6_blk_rd_in_reset got=%b req=0", blk_rd); end
    rst = 1'b0;
    wait_bits(3, 60, ok);
    repeat (6) step();
    total++;
    if (mon_bit.size() !== 3) begin
      bad++; $display("[TB] FAIL t6_post_reset_count got=%0d req=3", mon_bit.size());
    end
    for (int i = 0; i < exp_bit.size() && i < mon_bit.size(); i++) begin
      total++;
      if ({mon_bit[i], mon_last[i], mon_err[i]} !== {exp_bit[i], exp_last[i], exp_err[i]}) begin
        bad++;
        $display("[TB] FAIL t6_post_bit[%0d] got=%b%b%b req=%b%b%b", i, mon_bit[i], mon_last[i],
                 mon_err[i], exp_bit[i], exp_last[i], exp_err[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b1;
    sign_full = 1'b0;
    $display("[TB] sign_scrambler bench start");
    test_reset();
    test_basic();
    test_full_block();
    test_stall_full();
    test_end_flag();
    test_bad_size();
    test_stall_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
